// File: rtl/adc_burst_pkg.sv
// Shared burst tags, FSM state encoding and payload width helper for the
// ADC burst assembler and its lane packer.
package adc_burst_pkg;

  localparam int TAG_FILL = 1;
  localparam int TAG_WFM  = 2;
  localparam int TAG_DATA = 3;
  localparam int TAG_CSUM = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL_HDR = 3'd1,
    ST_WFM_HDR  = 3'd2,
    ST_DATA     = 3'd3,
    ST_CSUM     = 3'd4
  } state_e;

  function automatic int payload_bits(input int samples, input int word_bits);
    return samples * word_bits;
  endfunction

endpackage

// File: rtl/adc_burst_pack.sv
// Unpacks {sample, ovr} lanes into sign-extended payload words and flags any
// over-range lane.
module adc_burst_pack
  import adc_burst_pkg::*;
#(
  parameter int ADC_BITS  = 12,
  parameter int SAMPLES   = 8,
  parameter int WORD_BITS = 16
) (
  input  logic [SAMPLES*(ADC_BITS+1)-1:0]              samp_dat_i,
  output logic [payload_bits(SAMPLES, WORD_BITS)-1:0] data_o,
  output logic                                         ovr_any_o
);

  localparam int LANE_BITS = ADC_BITS + 1;

  logic [SAMPLES-1:0] ovr_vec;

  for (genvar i = 0; i < SAMPLES; i++) begin : g_lane
    logic [LANE_BITS-1:0] lane;
    assign lane       = samp_dat_i[i*LANE_BITS +: LANE_BITS];
    assign ovr_vec[i] = lane[0];
    // The over-range flag sits at the lane LSB, so the sample MSB is lane[ADC_BITS].
    if (WORD_BITS > ADC_BITS) begin : g_ext
      assign data_o[i*WORD_BITS +: WORD_BITS] =
        {{(WORD_BITS-ADC_BITS){lane[ADC_BITS]}}, lane[ADC_BITS:1]};
    end else begin : g_fit
      assign data_o[i*WORD_BITS +: WORD_BITS] = lane[ADC_BITS:1];
    end
  end

  assign ovr_any_o = |ovr_vec;

endmodule

// File: rtl/adc_burst_assembler.sv
// Sequences one fill record (fill header, per-waveform header + data bursts,
// XOR checksum) as tagged bursts into a registered valid/ready output stage.
module adc_burst_assembler
  import adc_burst_pkg::*;
#(
  parameter  int ADC_BITS  = 12,
  parameter  int SAMPLES   = 8,
  parameter  int WORD_BITS = 16,
  parameter  int TAG_BITS  = 4,
  parameter  int CNT_BITS  = 23,
  localparam int PAYLOAD   = payload_bits(SAMPLES, WORD_BITS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  input  logic [CNT_BITS-1:0]             num_waveforms_i,
  input  logic [13:0]                     bursts_per_wfm_i,
  input  logic [PAYLOAD-1:0]              fill_hdr_body_i,
  input  logic [PAYLOAD-1:0]              wfm_hdr_body_i,
  input  logic                            wfm_hdr_valid_i,
  output logic                            wfm_hdr_ready_o,
  input  logic [SAMPLES*(ADC_BITS+1)-1:0] samp_dat_i,
  input  logic                            samp_valid_i,
  output logic                            samp_ready_o,
  output logic [TAG_BITS+PAYLOAD-1:0]     out_dat_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [CNT_BITS-1:0]             burst_count_o,
  output logic                            ovr_seen_o
);

  localparam logic [TAG_BITS-1:0] T_FILL = TAG_BITS'(TAG_FILL);
  localparam logic [TAG_BITS-1:0] T_WFM  = TAG_BITS'(TAG_WFM);
  localparam logic [TAG_BITS-1:0] T_DATA = TAG_BITS'(TAG_DATA);
  localparam logic [TAG_BITS-1:0] T_CSUM = TAG_BITS'(TAG_CSUM);

  state_e                        state_q, state_d;
  logic [CNT_BITS-1:0]           nwfm_q, wfm_cnt_q, wfm_cnt_d, burst_count_q;
  logic [13:0]                   nburst_q, data_cnt_q, data_cnt_d;
  logic [PAYLOAD-1:0]            fill_hdr_q, csum_q, csum_d, pack_data;
  logic [TAG_BITS+PAYLOAD-1:0]   out_dat_q, out_dat_d;
  logic                          out_valid_q, out_valid_d;
  logic                          done_q, ovr_seen_q, csum_sent_q, pack_ovr;
  logic                          can_load, xfer, start_ok, wfm_hs, samp_hs;
  logic                          load_fill, load_csum, csum_done;

  adc_burst_pack #(
    .ADC_BITS (ADC_BITS),
    .SAMPLES  (SAMPLES),
    .WORD_BITS(WORD_BITS)
  ) u_pack (
    .samp_dat_i(samp_dat_i),
    .data_o    (pack_data),
    .ovr_any_o (pack_ovr)
  );

  // The output slot may be refilled when it is empty or draining this cycle.
  assign can_load  = !out_valid_q || out_ready_i;
  assign xfer      = out_valid_q && out_ready_i;
  assign start_ok  = (state_q == ST_IDLE) && start_i && !done_q;
  assign wfm_hs    = wfm_hdr_valid_i && (state_q == ST_WFM_HDR) && can_load;
  assign samp_hs   = samp_valid_i && (state_q == ST_DATA) && can_load;
  assign csum_done = (state_q == ST_CSUM) && csum_sent_q && xfer;

  // Folding the burst that drains this cycle lets the checksum load back-to-back.
  assign csum_d = (xfer && (out_dat_q[PAYLOAD +: TAG_BITS] != T_CSUM)) ?
                  (csum_q ^ out_dat_q[PAYLOAD-1:0]) : csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    wfm_cnt_d  = wfm_cnt_q;
    data_cnt_d = data_cnt_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_FILL_HDR;
      ST_FILL_HDR: begin
        if (can_load) begin
          wfm_cnt_d = '0;
          state_d   = (nwfm_q == '0) ? ST_CSUM : ST_WFM_HDR;
        end
      end
      ST_WFM_HDR: begin
        if (wfm_hs) begin
          wfm_cnt_d  = wfm_cnt_q + CNT_BITS'(1);
          data_cnt_d = '0;
          if (nburst_q != '0)          state_d = ST_DATA;
          else if (wfm_cnt_d == nwfm_q) state_d = ST_CSUM;
        end
      end
      ST_DATA: begin
        if (samp_hs) begin
          data_cnt_d = data_cnt_q + 14'd1;
          if (data_cnt_d == nburst_q)
            state_d = (wfm_cnt_q == nwfm_q) ? ST_CSUM : ST_WFM_HDR;
        end
      end
      ST_CSUM: if (csum_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wfm_hdr_ready_o = (state_q == ST_WFM_HDR) && can_load;
    samp_ready_o    = (state_q == ST_DATA) && can_load;
    busy_o          = (state_q != ST_IDLE);
    load_fill       = (state_q == ST_FILL_HDR) && can_load;
    load_csum       = (state_q == ST_CSUM) && !csum_sent_q && can_load;
    out_valid_d     = out_valid_q && !out_ready_i;
    out_dat_d       = out_dat_q;
    if (load_fill) begin
      out_valid_d = 1'b1;
      out_dat_d   = {T_FILL, fill_hdr_q};
    end else if (wfm_hs) begin
      out_valid_d = 1'b1;
      out_dat_d   = {T_WFM, wfm_hdr_body_i};
    end else if (samp_hs) begin
      out_valid_d = 1'b1;
      out_dat_d   = {T_DATA, pack_data};
    end else if (load_csum) begin
      out_valid_d = 1'b1;
      out_dat_d   = {T_CSUM, csum_d};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_dat_q     <= '0;
      nwfm_q        <= '0;
      nburst_q      <= '0;
      fill_hdr_q    <= '0;
      wfm_cnt_q     <= '0;
      data_cnt_q    <= '0;
      csum_q        <= '0;
      csum_sent_q   <= 1'b0;
      burst_count_q <= '0;
      ovr_seen_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_dat_q   <= out_dat_d;
      wfm_cnt_q   <= wfm_cnt_d;
      data_cnt_q  <= data_cnt_d;
      done_q      <= csum_done;
      if (start_ok) begin
        nwfm_q        <= num_waveforms_i;
        nburst_q      <= bursts_per_wfm_i;
        fill_hdr_q    <= fill_hdr_body_i;
        csum_q        <= '0;
        csum_sent_q   <= 1'b0;
        burst_count_q <= '0;
        ovr_seen_q    <= 1'b0;
      end else begin
        csum_q <= csum_d;
        if (xfer)              burst_count_q <= burst_count_q + CNT_BITS'(1);
        if (samp_hs && pack_ovr) ovr_seen_q  <= 1'b1;
        if (load_csum)         csum_sent_q   <= 1'b1;
      end
    end
  end

  assign out_dat_o     = out_dat_q;
  assign out_valid_o   = out_valid_q;
  assign done_o        = done_q;
  assign burst_count_o = burst_count_q;
  assign ovr_seen_o    = ovr_seen_q;

endmodule

// File: tb/tb_adc_burst_assembler.sv
// Randomised fills checked burst-by-burst against a record-level reference
// model built from the fill parameters, headers and sample lanes.
module tb_adc_burst_assembler;

  localparam int ADC   = 12;
  localparam int NS    = 8;
  localparam int WB    = 16;
  localparam int TAGW  = 4;
  localparam int CNTB  = 23;
  localparam int PAY   = NS * WB;
  localparam int OUTW  = TAGW + PAY;
  localparam int LANEW = ADC + 1;
  localparam int SAMPW = NS * LANEW;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [CNTB-1:0]  num_waveforms_i;
  logic [13:0]      bursts_per_wfm_i;
  logic [PAY-1:0]   fill_hdr_body_i, wfm_hdr_body_i;
  logic             wfm_hdr_valid_i, wfm_hdr_ready_o;
  logic [SAMPW-1:0] samp_dat_i;
  logic             samp_valid_i, samp_ready_o;
  logic [OUTW-1:0]  out_dat_o;
  logic             out_valid_o, out_ready_i;
  logic             busy_o, done_o, ovr_seen_o;
  logic [CNTB-1:0]  burst_count_o;

  adc_burst_assembler #(
    .ADC_BITS(ADC), .SAMPLES(NS), .WORD_BITS(WB), .TAG_BITS(TAGW), .CNT_BITS(CNTB)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .num_waveforms_i(num_waveforms_i), .bursts_per_wfm_i(bursts_per_wfm_i),
    .fill_hdr_body_i(fill_hdr_body_i), .wfm_hdr_body_i(wfm_hdr_body_i),
    .wfm_hdr_valid_i(wfm_hdr_valid_i), .wfm_hdr_ready_o(wfm_hdr_ready_o),
    .samp_dat_i(samp_dat_i), .samp_valid_i(samp_valid_i), .samp_ready_o(samp_ready_o),
    .out_dat_o(out_dat_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .done_o(done_o), .burst_count_o(burst_count_o), .ovr_seen_o(ovr_seen_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [PAY-1:0]   hdrQ[$];
  logic [SAMPW-1:0] sampQ[$];
  logic [OUTW-1:0]  expQ[$];
  logic [PAY-1:0]   fillHdr, expCsum, seenCsum, seenData;
  logic             expOvr;
  logic             useDirected = 1'b0;
  int               curW, curB;

  task automatic checkOutput(input string name, input logic [OUTW-1:0] observed,
                             input logic [OUTW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Each lane value is read as a signed ADC code and re-encoded as a 16-bit word.
  function automatic logic [PAY-1:0] packModel(input logic [SAMPW-1:0] s);
    logic [PAY-1:0]   r;
    logic [SAMPW-1:0] sh;
    int               code;
    r = '0;
    for (int i = 0; i < NS; i++) begin
      sh   = s >> (i * LANEW);
      code = int'(sh[LANEW-1:0]) / 2;
      if (code >= (1 << (ADC - 1))) code = code - (1 << ADC);
      r[i*WB +: WB] = WB'(code);
    end
    return r;
  endfunction

  task automatic prepareFill(input int nW, input int nB, input int ovrPolicy);
    logic [127:0]     r;
    logic [SAMPW-1:0] s;
    logic [PAY-1:0]   p;
    hdrQ.delete(); sampQ.delete(); expQ.delete();
    curW = nW; curB = nB;
    fillHdr = rand128();
    expCsum = fillHdr;
    expOvr  = 1'b0;
    expQ.push_back({4'd1, fillHdr});
    for (int w = 0; w < nW; w++) begin
      p = rand128();
      hdrQ.push_back(p);
      expQ.push_back({4'd2, p});
      expCsum ^= p;
      for (int b = 0; b < nB; b++) begin
        r = rand128();
        s = r[SAMPW-1:0];
        for (int l = 0; l < NS; l++) begin
          if (ovrPolicy == 1) s[l*LANEW] = 1'b0;
          if (ovrPolicy == 2) s[l*LANEW] = 1'b1;
        end
        if (useDirected && sampQ.size() == 0) s[2*LANEW-1:0] = {13'h0FFF, 13'h1000};
        for (int l = 0; l < NS; l++) if (s[l*LANEW]) expOvr = 1'b1;
        sampQ.push_back(s);
        p = packModel(s);
        expQ.push_back({4'd3, p});
        expCsum ^= p;
      end
    end
    expQ.push_back({4'd4, expCsum});
  endtask

  task automatic applyStimulus(input int readyMode, input int abortAt, input bit startIgnore);
    int              hIdx, sIdx, oIdx, firstCyc, lastCyc;
    logic            doneExp, doneSeen, held, xfer, hsH, hsS, gotData;
    logic [OUTW-1:0] heldDat;
    hIdx = 0; sIdx = 0; oIdx = 0; firstCyc = -1; lastCyc = -1;
    doneExp = 1'b0; doneSeen = 1'b0; held = 1'b0; gotData = 1'b0; heldDat = '0;
    @(negedge clk);
    checkOutput("idle_busy_before", busy_o, 0);
    start_i = 1'b1; num_waveforms_i = CNTB'(curW); bursts_per_wfm_i = 14'(curB);
    fill_hdr_body_i = fillHdr; out_ready_i = 1'b1;
    wfm_hdr_valid_i = 1'b0; samp_valid_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    num_waveforms_i = CNTB'($urandom_range(1, 5)); bursts_per_wfm_i = 14'($urandom_range(1, 5));
    fill_hdr_body_i = rand128();
    checkOutput("busy_rise", busy_o, 1);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      checkOutput("done_pulse", done_o, doneExp);
      if (held) begin
        checkOutput("stall_valid", out_valid_o, 1);
        checkOutput("stall_data", out_dat_o, heldDat);
      end
      if (doneExp) begin
        doneSeen = 1'b1;
        start_i  = startIgnore;
        break;
      end
      start_i = startIgnore && (cyc == 3);
      wfm_hdr_valid_i = (hIdx < hdrQ.size());
      if (wfm_hdr_valid_i) wfm_hdr_body_i = hdrQ[hIdx]; else wfm_hdr_body_i = rand128();
      samp_valid_i = (sIdx < sampQ.size());
      if (samp_valid_i) samp_dat_i = sampQ[sIdx]; else samp_dat_i = SAMPW'(rand128());
      case (readyMode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      xfer = out_valid_o && out_ready_i;
      hsH  = wfm_hdr_valid_i && wfm_hdr_ready_o;
      hsS  = samp_valid_i && samp_ready_o;
      doneExp = 1'b0;
      if (xfer) begin
        if (oIdx < expQ.size()) checkOutput("burst", out_dat_o, expQ[oIdx]);
        else                    checkOutput("extra_burst", oIdx, expQ.size());
        if (out_dat_o[PAY +: TAGW] == 4'd3 && !gotData) begin
          seenData = out_dat_o[PAY-1:0];
          gotData  = 1'b1;
        end
        if (out_dat_o[PAY +: TAGW] == 4'd4) begin
          seenCsum = out_dat_o[PAY-1:0];
          doneExp  = 1'b1;
        end
        if (firstCyc < 0) firstCyc = cyc;
        lastCyc = cyc;
        oIdx++;
      end
      held    = out_valid_o && !out_ready_i;
      heldDat = out_dat_o;
      if (hsH) hIdx++;
      if (hsS) sIdx++;
      if (abortAt > 0 && hIdx == abortAt && hsS) begin
        @(posedge clk);
        #1;
        checkOutput("pre_rst_ovr", ovr_seen_o, expOvr);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", out_valid_o, 0);
        checkOutput("rst_out_dat", out_dat_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_samp_ready", samp_ready_o, 0);
        checkOutput("rst_burst_count", burst_count_o, 0);
        checkOutput("rst_ovr_seen", ovr_seen_o, 0);
        @(negedge clk);
        rst = 1'b0; wfm_hdr_valid_i = 1'b0; samp_valid_i = 1'b0; start_i = 1'b0;
        return;
      end
    end
    wfm_hdr_valid_i = 1'b0; samp_valid_i = 1'b0;
    checkOutput("fill_done", doneSeen, 1);
    checkOutput("bursts_seen", oIdx, expQ.size());
    checkOutput("burst_count", burst_count_o, expQ.size());
    checkOutput("ovr_seen", ovr_seen_o, expOvr);
    if (readyMode == 0) checkOutput("throughput", lastCyc - firstCyc, expQ.size() - 1);
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_busy_after", busy_o, 0);
      checkOutput("idle_valid_after", out_valid_o, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; num_waveforms_i = '0; bursts_per_wfm_i = '0;
    fill_hdr_body_i = '0; wfm_hdr_body_i = '0; wfm_hdr_valid_i = 1'b0;
    samp_dat_i = '0; samp_valid_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", out_valid_o, 0);
    checkOutput("reset_out_dat", out_dat_o, 0);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_done", done_o, 0);
    checkOutput("reset_burst_count", burst_count_o, 0);
    checkOutput("reset_ovr_seen", ovr_seen_o, 0);
    checkOutput("reset_samp_ready", samp_ready_o, 0);
    checkOutput("reset_wfm_ready", wfm_hdr_ready_o, 0);
    rst = 1'b0;

    $display("[TB] basic fill");
    prepareFill(1, 2, 0);
    applyStimulus(0, 0, 1'b0);
    checkOutput("basic_csum", seenCsum, expCsum);

    $display("[TB] backpressure, same record");
    applyStimulus(1, 0, 1'b0);
    checkOutput("bp_csum", seenCsum, expCsum);
    prepareFill(3, 3, 0);
    applyStimulus(2, 0, 1'b0);

    $display("[TB] sign extension");
    useDirected = 1'b1;
    prepareFill(1, 1, 0);
    useDirected = 1'b0;
    applyStimulus(0, 0, 1'b0);
    checkOutput("sext_word0", seenData[15:0], 16'hF800);
    checkOutput("sext_word1", seenData[31:16], 16'h07FF);
    checkOutput("sext_ovr", ovr_seen_o, 1);

    $display("[TB] empty cases");
    prepareFill(0, 3, 0);
    applyStimulus(0, 0, 1'b0);
    checkOutput("empty_csum", seenCsum, fillHdr);
    prepareFill(2, 0, 0);
    applyStimulus(2, 0, 1'b0);

    $display("[TB] reset mid-fill and restart");
    prepareFill(4, 2, 2);
    applyStimulus(0, 3, 1'b0);
    prepareFill(2, 2, 1);
    applyStimulus(0, 0, 1'b0);
    checkOutput("restart_csum", seenCsum, expCsum);

    $display("[TB] ignored starts");
    prepareFill(1, 2, 0);
    applyStimulus(0, 0, 1'b1);

    $display("[TB] random fills");
    for (int k = 0; k < 4; k++) begin
      prepareFill($urandom_range(0, 3), $urandom_range(0, 3), 0);
      applyStimulus(2, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
